bcd_scan_display: RTL and testbench

- Downstream consumer of the 8-bit adder result.
- Captures the 12-bit Sum (BCD or binary) on a load strobe, then time-multiplexes it onto a 3-digit common-segment 7-seg display.
- Supports leading-zero blanking and flags invalid BCD nibbles.
- Replaces the static two-digit dpy0/dpy1 drive with a scanned three-digit drive, so the hundreds digit of a BCD sum can be shown.

---
 rtl/bcd_disp_pkg.sv | 35 +++
 rtl/seg7_glyph.sv | 42 ++++
 rtl/bcd_scan_display.sv | 131 +++++++++++++
 tb/tb_bcd_scan_display.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_disp_pkg
// Purpose  : Shared glyph, anode and digit-count constants for the scan display
// Revision : 1.0
// ============================================================================
package bcd_disp_pkg;

    localparam int NUM_DIGITS = 3;

    typedef logic [1:0] digit_idx_t;

    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_A     = 8'h77;
    localparam logic [7:0] SEG_B     = 8'h7C;
    localparam logic [7:0] SEG_C     = 8'h39;
    localparam logic [7:0] SEG_D     = 8'h5E;
    localparam logic [7:0] SEG_E     = 8'h79;
    localparam logic [7:0] SEG_F     = 8'h71;
    localparam logic [7:0] SEG_DASH  = 8'h40;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    localparam logic [2:0] AN_OFF    = 3'b111;

endpackage
`default_nettype wire

// File: rtl/seg7_glyph.sv
`default_nettype none
// ============================================================================
// Module   : seg7_glyph
// Purpose  : Nibble to 7-segment glyph; non-decimal nibbles show a dash in BCD
// Revision : 1.0
// ============================================================================
module seg7_glyph
    import bcd_disp_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       bcd_mode,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (bcd_mode && (nibble > 4'd9)) begin
            seg = SEG_DASH;
        end else begin
            case (nibble)
                4'h0: seg = SEG_0;
                4'h1: seg = SEG_1;
                4'h2: seg = SEG_2;
                4'h3: seg = SEG_3;
                4'h4: seg = SEG_4;
                4'h5: seg = SEG_5;
                4'h6: seg = SEG_6;
                4'h7: seg = SEG_7;
                4'h8: seg = SEG_8;
                4'h9: seg = SEG_9;
                4'hA: seg = SEG_A;
                4'hB: seg = SEG_B;
                4'hC: seg = SEG_C;
                4'hD: seg = SEG_D;
                4'hE: seg = SEG_E;
                default: seg = SEG_F;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : bcd_scan_display
// Purpose  : Captures a 12-bit sum and scans it onto a 3-digit 7-seg display
// Revision : 1.0
// ============================================================================
module bcd_scan_display
    import bcd_disp_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DIV_W    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ctrl,
    input  logic        load,
    input  logic [11:0] value,
    input  logic        bcd_mode,
    input  logic        blank_lz,
    output logic [7:0]  seg,
    output logic [2:0]  an,
    output logic        err,
    output logic        frame_done
);

    localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(SCAN_DIV - 1);

    logic [11:0]      hold_q,  hold_d;
    logic             mode_q,  mode_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    digit_idx_t       idx_q,   idx_d;
    logic [7:0]       seg_q,   seg_d;
    logic [2:0]       an_q,    an_d;
    logic             err_q,   err_d;
    logic             frame_done_q, frame_done_d;

    logic [3:0]            nib    [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] nib_gt9;
    logic [3:0]            sel_nib;
    logic [7:0]            glyph;
    logic                  blanked;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_nib
        assign nib[i]     = hold_q[4*i +: 4];
        assign nib_gt9[i] = (hold_q[4*i +: 4] > 4'd9);
    end

    seg7_glyph u_glyph (
        .nibble   (sel_nib),
        .bcd_mode (mode_q),
        .seg      (glyph)
    );

    always_comb begin
        hold_d       = load ? value    : hold_q;
        mode_d       = load ? bcd_mode : mode_q;
        presc_d      = presc_q;
        idx_d        = idx_q;
        frame_done_d = 1'b0;

        if (ctrl) begin
            presc_d = '0;
            idx_d   = 2'd0;
        end else if (presc_q == PRESC_LAST) begin
            presc_d      = '0;
            idx_d        = (idx_q >= 2'd2) ? 2'd0 : idx_q + 2'd1;
            frame_done_d = (idx_q == 2'd2);
        end else begin
            presc_d = presc_q + DIV_W'(1);
            // An out-of-range index is recovered on the very next edge.
            if (idx_q == 2'd3) begin
                idx_d = 2'd0;
            end
        end
    end

    always_comb begin
        sel_nib = nib[0];
        blanked = 1'b0;
        case (idx_q)
            2'd1: begin
                sel_nib = nib[1];
                blanked = blank_lz && (nib[2] == 4'd0) && (nib[1] == 4'd0);
            end
            2'd2: begin
                sel_nib = nib[2];
                blanked = blank_lz && (nib[2] == 4'd0);
            end
            2'd3:    blanked = 1'b1;
            default: blanked = 1'b0;
        endcase

        seg_d = SEG_BLANK;
        an_d  = AN_OFF;
        if (!ctrl && !blanked) begin
            seg_d = glyph;
            an_d  = ~(3'b001 << idx_q);
        end

        err_d = mode_q & (|nib_gt9);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q       <= '0;
            mode_q       <= 1'b0;
            presc_q      <= '0;
            idx_q        <= 2'd0;
            seg_q        <= SEG_BLANK;
            an_q         <= AN_OFF;
            err_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            mode_q       <= mode_d;
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            err_q        <= err_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign err        = err_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_scan_display
// Purpose  : Scoreboard bench for the scanned 3-digit BCD display
// Revision : 1.0
// ============================================================================
module tb_bcd_scan_display;

    localparam int SCAN_DIV = 4;
    localparam int DIV_W    = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ctrl = 1'b0;
    logic        load = 1'b0;
    logic [11:0] value = '0;
    logic        bcd_mode = 1'b0;
    logic        blank_lz = 1'b0;
    logic [7:0]  seg;
    logic [2:0]  an;
    logic        err;
    logic        frame_done;

    typedef struct packed {
        logic [2:0] an;
        logic [7:0] seg;
        logic       fd;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bcd_scan_display #(.SCAN_DIV(SCAN_DIV), .DIV_W(DIV_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ctrl       (ctrl),
        .load       (load),
        .value      (value),
        .bcd_mode   (bcd_mode),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .an         (an),
        .err        (err),
        .frame_done (frame_done)
    );

    // Expected per-cycle outputs for one full frame starting at digit 0.
    task automatic push_frame(input logic [7:0] g0, input logic [2:0] a0,
                              input logic [7:0] g1, input logic [2:0] a1,
                              input logic [7:0] g2, input logic [2:0] a2,
                              input logic e);
        exp_t x;
        for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < SCAN_DIV; c++) begin
                x.an  = (d == 0) ? a0 : (d == 1) ? a1 : a2;
                x.seg = (d == 0) ? g0 : (d == 1) ? g1 : g2;
                x.fd  = (d == 2) && (c == SCAN_DIV - 1);
                x.err = e;
                sb.push_back(x);
            end
        end
    endtask

    task automatic wait_frame(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (frame_done !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL %s_sync: frame_done got %b want 1 within 64 cycles", nm, frame_done);
        end
    endtask

    task automatic do_load(input logic [11:0] v, input logic bm);
        @(negedge clk);
        value    = v;
        bcd_mode = bm;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({an, seg, err, frame_done} !== {3'b111, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: got an=%b seg=%h err=%b fd=%b want an=111 seg=00 err=0 fd=0",
                     an, seg, err, frame_done);
        end
    endtask

    task automatic test_basic_scan;
        exp_t x;
        value    = 12'h123;
        bcd_mode = 1'b1;
        blank_lz = 1'b1;
        ctrl     = 1'b0;
        load     = 1'b1;
        rst_n    = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if ({an, seg} !== {3'b110, 8'h3F}) begin
            errors++;
            $display("FAIL basic_pre_latency: got an=%b seg=%h want an=110 seg=3F", an, seg);
        end
        @(negedge clk);
        checks++;
        if ({an, seg, err} !== {3'b110, 8'h4F, 1'b0}) begin
            errors++;
            $display("FAIL basic_latency: got an=%b seg=%h err=%b want an=110 seg=4F err=0", an, seg, err);
        end
        push_frame(8'h4F, 3'b110, 8'h5B, 3'b101, 8'h06, 3'b011, 1'b0);
        push_frame(8'h4F, 3'b110, 8'h5B, 3'b101, 8'h06, 3'b011, 1'b0);
        wait_frame("basic");
        while (sb.size() > 0) begin
            @(negedge clk);
            x = sb.pop_front();
            checks++;
            if ({an, seg, frame_done, err} !== {x.an, x.seg, x.fd, x.err}) begin
                errors++;
                $display("FAIL basic_frame: got an=%b seg=%h fd=%b err=%b want an=%b seg=%h fd=%b err=%b",
                         an, seg, frame_done, err, x.an, x.seg, x.fd, x.err);
            end
        end
    endtask

    task automatic test_blanking;
        exp_t x;
        blank_lz = 1'b1;
        do_load(12'h005, 1'b1);
        push_frame(8'h6D, 3'b110, 8'h00, 3'b111, 8'h00, 3'b111, 1'b0);
        wait_frame("blank_on");
        while (sb.size() > 0) begin
            @(negedge clk);
            x = sb.pop_front();
            checks++;
            if ({an, seg, frame_done, err} !== {x.an, x.seg, x.fd, x.err}) begin
                errors++;
                $display("FAIL blank_on: got an=%b seg=%h fd=%b err=%b want an=%b seg=%h fd=%b err=%b",
                         an, seg, frame_done, err, x.an, x.seg, x.fd, x.err);
            end
        end
        blank_lz = 1'b0;
        push_frame(8'h6D, 3'b110, 8'h3F, 3'b101, 8'h3F, 3'b011, 1'b0);
        wait_frame("blank_off");
        while (sb.size() > 0) begin
            @(negedge clk);
            x = sb.pop_front();
            checks++;
            if ({an, seg, frame_done, err} !== {x.an, x.seg, x.fd, x.err}) begin
                errors++;
                $display("FAIL blank_off: got an=%b seg=%h fd=%b err=%b want an=%b seg=%h fd=%b err=%b",
                         an, seg, frame_done, err, x.an, x.seg, x.fd, x.err);
            end
        end
    endtask

    task automatic test_invalid_bcd;
        exp_t x;
        blank_lz = 1'b0;
        @(negedge clk);
        value    = 12'h0AF;
        bcd_mode = 1'b1;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_early: got err=%b want 0", err);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_set: got err=%b want 1", err);
        end
        push_frame(8'h40, 3'b110, 8'h40, 3'b101, 8'h3F, 3'b011, 1'b1);
        wait_frame("bcd_bad");
        while (sb.size() > 0) begin
            @(negedge clk);
            x = sb.pop_front();
            checks++;
            if ({an, seg, frame_done, err} !== {x.an, x.seg, x.fd, x.err}) begin
                errors++;
                $display("FAIL bcd_bad: got an=%b seg=%h fd=%b err=%b want an=%b seg=%h fd=%b err=%b",
                         an, seg, frame_done, err, x.an, x.seg, x.fd, x.err);
            end
        end
        do_load(12'h0AF, 1'b0);
        push_frame(8'h71, 3'b110, 8'h77, 3'b101, 8'h3F, 3'b011, 1'b0);
        wait_frame("hex");
        while (sb.size() > 0) begin
            @(negedge clk);
            x = sb.pop_front();
            checks++;
            if ({an, seg, frame_done, err} !== {x.an, x.seg, x.fd, x.err}) begin
                errors++;
                $display("FAIL hex: got an=%b seg=%h fd=%b err=%b want an=%b seg=%h fd=%b err=%b",
                         an, seg, frame_done, err, x.an, x.seg, x.fd, x.err);
            end
        end
    endtask

    task automatic test_back_to_back;
        exp_t x;
        blank_lz = 1'b0;
        @(negedge clk);
        bcd_mode = 1'b1;
        value    = 12'h111;
        load     = 1'b1;
        @(negedge clk);
        value    = 12'h999;
        @(negedge clk);
        load     = 1'b0;
        push_frame(8'h6F, 3'b110, 8'h6F, 3'b101, 8'h6F, 3'b011, 1'b0);
        wait_frame("b2b");
        while (sb.size() > 0) begin
            @(negedge clk);
            x = sb.pop_front();
            checks++;
            if ({an, seg, frame_done, err} !== {x.an, x.seg, x.fd, x.err}) begin
                errors++;
                $display("FAIL b2b: got an=%b seg=%h fd=%b err=%b want an=%b seg=%h fd=%b err=%b",
                         an, seg, frame_done, err, x.an, x.seg, x.fd, x.err);
            end
        end
    endtask

    task automatic test_ctrl_gating;
        blank_lz = 1'b1;
        do_load(12'h123, 1'b1);
        wait_frame("ctrl");
        repeat (SCAN_DIV + 2) @(negedge clk);
        checks++;
        if ({an, seg} !== {3'b101, 8'h5B}) begin
            errors++;
            $display("FAIL ctrl_mid_digit1: got an=%b seg=%h want an=101 seg=5B", an, seg);
        end
        ctrl = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, frame_done} !== {3'b111, 8'h00, 1'b0}) begin
                errors++;
                $display("FAIL ctrl_off[%0d]: got an=%b seg=%h fd=%b want an=111 seg=00 fd=0",
                         i, an, seg, frame_done);
            end
        end
        ctrl = 1'b0;
        for (int i = 0; i < SCAN_DIV; i++) begin
            @(negedge clk);
            checks++;
            if ({an, seg} !== {3'b110, 8'h4F}) begin
                errors++;
                $display("FAIL ctrl_restart[%0d]: got an=%b seg=%h want an=110 seg=4F", i, an, seg);
            end
        end
        @(negedge clk);
        checks++;
        if ({an, seg} !== {3'b101, 8'h5B}) begin
            errors++;
            $display("FAIL ctrl_next_digit: got an=%b seg=%h want an=101 seg=5B", an, seg);
        end
    endtask

    task automatic test_async_reset;
        exp_t x;
        blank_lz = 1'b1;
        do_load(12'h0AF, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_err: got err=%b want 1", err);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({an, seg, err, frame_done} !== {3'b111, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_async: got an=%b seg=%h err=%b fd=%b want an=111 seg=00 err=0 fd=0",
                     an, seg, err, frame_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push_frame(8'h3F, 3'b110, 8'h00, 3'b111, 8'h00, 3'b111, 1'b0);
        wait_frame("rst_after");
        while (sb.size() > 0) begin
            @(negedge clk);
            x = sb.pop_front();
            checks++;
            if ({an, seg, frame_done, err} !== {x.an, x.seg, x.fd, x.err}) begin
                errors++;
                $display("FAIL rst_after: got an=%b seg=%h fd=%b err=%b want an=%b seg=%h fd=%b err=%b",
                         an, seg, frame_done, err, x.an, x.seg, x.fd, x.err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_blanking();
        test_invalid_bcd();
        test_back_to_back();
        test_ctrl_gating();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
